asa_rci2sci_table_mem: RTL and testbench

- PIO-accessible RCI-to-SCI translation table; sits directly downstream of the ASA PIO decoder.
- Consumes the decoder's table select (reg_ms_rci2sci_table) and the shared PIO bus. Returns rci2sci_table_mem_ack and rci2sci_table_mem_rdata to the decoder.
- Also serves a single-cycle-issue lookup port for the ASA datapath. The datapath and PIO share one single-port RAM.

---
 rtl/asa_rci2sci_table_mem.sv | 163 ++++++++++++++++
 tb/tb_asa_rci2sci_table_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/asa_rci2sci_table_mem.sv
// ---------------------------------------------------------------------------
// asa_rci2sci_table_mem
//   RCI-to-SCI translation table shared between the ASA PIO decoder and the
//   ASA datapath lookup port. One single-port RAM, one access per cycle.
//   Lookups win arbitration by default; a PIO access that has lost
//   STARVE_MAX consecutive cycles is forced through.
//
// Ports:
//   clk, rst_n                 core clock, synchronous active-low reset
//   clk_div                    PIO strobe-rate pulse (one clk wide)
//   reg_ms_rci2sci_table       table select from the PIO decoder (level)
//   reg_wr / reg_rd            PIO write / read pulses
//   reg_addr / reg_din         PIO byte address / write data
//   rci2sci_table_mem_ack      access complete (level, held until release)
//   rci2sci_table_mem_rdata    PIO read data (zero-extended entry)
//   lkup_valid / lkup_rci      datapath lookup request / index
//   lkup_ready                 lookup accepted this cycle
//   lkup_sci_valid / lkup_sci  lookup result, one cycle after acceptance
//   lkup_perr                  parity error on lookup result
//
// Build option:
//   ASA_RCI2SCI_PARITY_EN  stores an even-parity bit per entry, reports
//                          mismatches on lkup_perr and PIO rdata MSB.
// ---------------------------------------------------------------------------
module asa_rci2sci_table_mem #(
   parameter int unsigned PIO_NBITS  = 32,
   parameter int unsigned ADDR_NBITS = 8,
   parameter int unsigned SCI_NBITS  = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_div,
   input  logic                  reg_ms_rci2sci_table,
   input  logic                  reg_wr,
   input  logic                  reg_rd,
   input  logic [PIO_NBITS-1:0]  reg_addr,
   input  logic [PIO_NBITS-1:0]  reg_din,
   output logic                  rci2sci_table_mem_ack,
   output logic [PIO_NBITS-1:0]  rci2sci_table_mem_rdata,
   input  logic                  lkup_valid,
   input  logic [ADDR_NBITS-1:0] lkup_rci,
   output logic                  lkup_ready,
   output logic                  lkup_sci_valid,
   output logic [SCI_NBITS-1:0]  lkup_sci,
   output logic                  lkup_perr
);

   localparam int unsigned DEPTH = 2**ADDR_NBITS;
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
`ifdef ASA_RCI2SCI_PARITY_EN
   localparam int unsigned ENTRY_NBITS = SCI_NBITS + 1;
`else
   localparam int unsigned ENTRY_NBITS = SCI_NBITS;
`endif

   typedef enum logic [1:0] {IDLE, REQ, RDWAIT, ACK} state_t;

   state_t                  state, state_nxt;
   logic                    cmd_wr;
   logic [ADDR_NBITS-1:0]   cmd_idx;
   logic [SCI_NBITS-1:0]    cmd_data;
   logic [CNT_W-1:0]        starve_cnt;

   logic [ENTRY_NBITS-1:0]  mem [DEPTH];
   logic [ENTRY_NBITS-1:0]  ram_q;
   logic [ENTRY_NBITS-1:0]  wr_entry;
   logic [ADDR_NBITS-1:0]   ram_addr;
   logic                    ram_we, ram_re;
   logic                    ram_perr;

   logic                    cmd_capture;
   logic                    pio_forced;
   logic                    pio_grant;
   logic [PIO_NBITS-1:0]    rdata_nxt;
   logic                    unused_bits;

   // Address bits outside the word index and data bits above the entry are
   // intentionally ignored.
   assign unused_bits = ^{reg_addr[PIO_NBITS-1:ADDR_NBITS+2], reg_addr[1:0],
                          reg_din[PIO_NBITS-1:SCI_NBITS]};

   assign cmd_capture = (state == IDLE) & (reg_rd | reg_wr) & reg_ms_rci2sci_table;
   assign pio_forced  = (state == REQ) & (starve_cnt == CNT_W'(STARVE_MAX));
   assign pio_grant   = (state == REQ) & (~lkup_valid | pio_forced);
   assign lkup_ready  = lkup_valid & ~pio_forced;

   // Lookup and PIO grant are mutually exclusive, so the lookup index can own
   // the address mux whenever a lookup is accepted.
   assign ram_addr = lkup_ready ? lkup_rci : cmd_idx;
   assign ram_we   = rst_n & pio_grant & cmd_wr;
   assign ram_re   = rst_n & (lkup_ready | (pio_grant & ~cmd_wr));

`ifdef ASA_RCI2SCI_PARITY_EN
   assign wr_entry = {^cmd_data, cmd_data};
   assign ram_perr = ^ram_q;
`else
   assign wr_entry = cmd_data;
   assign ram_perr = 1'b0;
`endif

   assign lkup_sci  = ram_q[SCI_NBITS-1:0];
   assign lkup_perr = lkup_sci_valid & ram_perr;
   assign rci2sci_table_mem_ack = (state == ACK);

   always_comb begin
      rdata_nxt                  = '0;
      rdata_nxt[SCI_NBITS-1:0]   = ram_q[SCI_NBITS-1:0];
      rdata_nxt[PIO_NBITS-1]     = ram_perr;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_capture) state_nxt = REQ;
         REQ:     if (pio_grant) state_nxt = cmd_wr ? ACK : RDWAIT;
         RDWAIT:  state_nxt = ACK;
         ACK:     if (clk_div & ~reg_ms_rci2sci_table) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (pio_grant)
            starve_cnt <= '0;
         else if (state == REQ)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_capture) begin
         cmd_wr   <= reg_wr;
         cmd_idx  <= reg_addr[ADDR_NBITS+1:2];
         cmd_data <= reg_din[SCI_NBITS-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         mem[ram_addr] <= wr_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_q                   <= '0;
         lkup_sci_valid          <= 1'b0;
         rci2sci_table_mem_rdata <= '0;
      end else begin
         if (ram_re)
            ram_q <= mem[ram_addr];
         lkup_sci_valid <= lkup_ready;
         if (state == RDWAIT)
            rci2sci_table_mem_rdata <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_asa_rci2sci_table_mem.sv
module tb_asa_rci2sci_table_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_div;
   logic        sel;
   logic        reg_wr, reg_rd;
   logic [31:0] reg_addr, reg_din;
   logic        ack;
   logic [31:0] rdata;
   logic        lkup_valid;
   logic [7:0]  lkup_rci;
   logic        lkup_ready;
   logic        lkup_sci_valid;
   logic [15:0] lkup_sci;
   logic        lkup_perr;

   int total = 0;
   int bad   = 0;

   asa_rci2sci_table_mem #(
      .PIO_NBITS (32),
      .ADDR_NBITS(8),
      .SCI_NBITS (16),
      .STARVE_MAX(4)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .clk_div                (clk_div),
      .reg_ms_rci2sci_table   (sel),
      .reg_wr                 (reg_wr),
      .reg_rd                 (reg_rd),
      .reg_addr               (reg_addr),
      .reg_din                (reg_din),
      .rci2sci_table_mem_ack  (ack),
      .rci2sci_table_mem_rdata(rdata),
      .lkup_valid             (lkup_valid),
      .lkup_rci               (lkup_rci),
      .lkup_ready             (lkup_ready),
      .lkup_sci_valid         (lkup_sci_valid),
      .lkup_sci               (lkup_sci),
      .lkup_perr              (lkup_perr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;      // 0 read, 1 write, 2 read+write together
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp_rdata; // checked for reads only
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Presents one PIO command and waits for ack; lat counts clocks from the
   // capture edge up to the edge after which ack is visible.
   task automatic pio_op(input int kind, input logic [31:0] addr, input logic [31:0] din,
                         output int lat);
      sel      = 1'b1;
      reg_addr = addr;
      reg_din  = din;
      reg_rd   = (kind != 1);
      reg_wr   = (kind != 0);
      lat = 0;
      do begin
         tick();
         reg_rd = 1'b0;
         reg_wr = 1'b0;
         lat++;
      end while (!ack && lat < 40);
      if (!ack) check("ack_timeout", 32'(lat), 32'd0);
   endtask

   task automatic pio_release();
      sel     = 1'b0;
      clk_div = 1'b1;
      tick();
      clk_div = 1'b0;
      check("ack_drop", 32'(ack), 32'd0);
   endtask

   int lat;
   logic [31:0] held;

   initial begin
      vecs[0]  = '{1, 32'h0000_0014, 32'h0000_ABCD, 32'h0,         2};
      vecs[1]  = '{0, 32'h0000_0014, 32'h0,         32'h0000_ABCD, 3};
      vecs[2]  = '{1, 32'h0000_0404, 32'hFFFF_0011, 32'h0,         2};
      vecs[3]  = '{1, 32'h0000_0008, 32'h0000_0022, 32'h0,         2};
      vecs[4]  = '{1, 32'h0000_000C, 32'h0000_0033, 32'h0,         2};
      vecs[5]  = '{0, 32'h0000_0004, 32'h0,         32'h0000_0011, 3};
      vecs[6]  = '{1, 32'h0007_FFFC, 32'h0000_BEEF, 32'h0,         2};
      vecs[7]  = '{0, 32'h0000_03FC, 32'h0,         32'h0000_BEEF, 3};
      vecs[8]  = '{1, 32'h0000_001C, 32'h0000_0055, 32'h0,         2};
      vecs[9]  = '{2, 32'h0000_0028, 32'h0000_0077, 32'h0,         2};
      vecs[10] = '{0, 32'h0000_0028, 32'h0,         32'h0000_0077, 3};
      vecs[11] = '{1, 32'h0000_0414, 32'h0000_5A5A, 32'h0,         2};

      rst_n = 1'b0; clk_div = 1'b0; sel = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
      reg_addr = '0; reg_din = '0; lkup_valid = 1'b0; lkup_rci = '0;
      repeat (3) tick();
      check("rst_ack",   32'(ack), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_valid", 32'(lkup_sci_valid), 32'd0);
      check("rst_perr",  32'(lkup_perr), 32'd0);
      check("rst_sci",   32'(lkup_sci), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         pio_op(vecs[i].kind, vecs[i].addr, vecs[i].din, lat);
         check($sformatf("lat[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
         if (vecs[i].kind == 0)
            check($sformatf("rdata[%0d]", i), rdata, vecs[i].exp_rdata);
         held = rdata;
         // clk_div while still selected must not release the access
         clk_div = 1'b1;
         tick();
         clk_div = 1'b0;
         check($sformatf("ack_hold[%0d]", i), 32'(ack), 32'd1);
         check($sformatf("rdata_hold[%0d]", i), rdata, held);
         pio_release();
      end

      // wrapped write landed on index 5
      pio_op(0, 32'h0000_0014, 32'h0, lat);
      check("wrap_rd", rdata, 32'h0000_5A5A);
      pio_release();
      lkup_valid = 1'b1; lkup_rci = 8'd5;
      #1 check("wrap_ready", 32'(lkup_ready), 32'd1);
      tick();
      lkup_valid = 1'b0;
      check("wrap_valid", 32'(lkup_sci_valid), 32'd1);
      check("wrap_sci", 32'(lkup_sci), 32'h5A5A);
      tick();
      check("wrap_valid_pulse", 32'(lkup_sci_valid), 32'd0);

      // back-to-back lookups
      lkup_valid = 1'b1; lkup_rci = 8'd1;
      tick();
      check("b2b_v1", 32'(lkup_sci_valid), 32'd1);
      check("b2b_s1", 32'(lkup_sci), 32'h11);
      lkup_rci = 8'd2;
      tick();
      check("b2b_v2", 32'(lkup_sci_valid), 32'd1);
      check("b2b_s2", 32'(lkup_sci), 32'h22);
      lkup_rci = 8'd3;
      tick();
      check("b2b_v3", 32'(lkup_sci_valid), 32'd1);
      check("b2b_s3", 32'(lkup_sci), 32'h33);
      lkup_valid = 1'b0;
      tick();
      check("b2b_end", 32'(lkup_sci_valid), 32'd0);

      // starvation: lookups held high while a PIO read of index 2 waits
      lkup_valid = 1'b1; lkup_rci = 8'd1;
      sel = 1'b1; reg_rd = 1'b1; reg_addr = 32'h8;
      tick();
      reg_rd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("starve_ready[%0d]", k), 32'(lkup_ready), 32'd1);
         check($sformatf("starve_ack[%0d]", k), 32'(ack), 32'd0);
         tick();
      end
      check("starve_forced", 32'(lkup_ready), 32'd0);
      tick();
      check("starve_resume", 32'(lkup_ready), 32'd1);
      check("starve_gap", 32'(lkup_sci_valid), 32'd0);
      tick();
      check("starve_ack", 32'(ack), 32'd1);
      check("starve_rdata", rdata, 32'h22);
      check("starve_lkv", 32'(lkup_sci_valid), 32'd1);
      check("starve_lks", 32'(lkup_sci), 32'h11);
      lkup_valid = 1'b0;
      pio_release();

      // write then lookup of same index in the next cycle
      pio_op(1, 32'h0000_0010, 32'h0000_0044, lat);
      lkup_valid = 1'b1; lkup_rci = 8'd4;
      tick();
      lkup_valid = 1'b0;
      check("raw_sci", 32'(lkup_sci), 32'h44);
      pio_release();

      // reset while the write to index 7 is about to be forced through
      lkup_valid = 1'b1; lkup_rci = 8'd0;
      sel = 1'b1; reg_wr = 1'b1; reg_addr = 32'h1C; reg_din = 32'h99;
      tick();
      reg_wr = 1'b0;
      repeat (4) tick();
      check("rmid_forced", 32'(lkup_ready), 32'd0);
      rst_n = 1'b0; sel = 1'b0;
      repeat (2) tick();
      check("rmid_ack", 32'(ack), 32'd0);
      check("rmid_valid", 32'(lkup_sci_valid), 32'd0);
      rst_n = 1'b1; lkup_valid = 1'b0;
      tick();
      pio_op(0, 32'h0000_001C, 32'h0, lat);
      check("rmid_rd", rdata, 32'h55);
      pio_release();

`ifdef ASA_RCI2SCI_PARITY_EN
      pio_op(1, 32'h0000_0024, 32'h0000_1234, lat);
      pio_release();
      dut.mem[9][16] = ~dut.mem[9][16];
      lkup_valid = 1'b1; lkup_rci = 8'd9;
      tick();
      lkup_valid = 1'b0;
      check("par_perr", 32'(lkup_perr), 32'd1);
      check("par_sci", 32'(lkup_sci), 32'h1234);
      pio_op(0, 32'h0000_0024, 32'h0, lat);
      check("par_rdata", rdata, 32'h8000_1234);
      pio_release();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
